// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the RAM6116 arbiter.
//   state_t   : access sequencer states
//   GRANT_*   : requester ids used for grant / last_grant
//   cnt_w()   : width of the per-access cycle counter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

  // Counter only ever holds ACCESS_CYCLES-1 down to 0.
  function automatic int cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[0]      : CPU request (already masked by loader mode)
//   req[1]      : loader request
//   last_grant  : id of the previous winner
//   grant_valid : any eligible request
//   grant_id    : winner id (GRANT_CPU / GRANT_LD)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    // On a tie the requester that did not win last time goes next;
    // otherwise the lone requester's index is its id.
    if (req == 2'b11) grant_id = ~last_grant;
    else              grant_id = req[1] ? GRANT_LD : GRANT_CPU;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port RAM6116 between the CPU memory path
// and the program loader / debug port.
//   clock, reset            : rising-edge clock, async active-low reset
//   ld_mode                 : masks CPU requests while a program is loaded
//   cpu_req/we/addr/wdata   : CPU request bundle, level held until cpu_ack
//   cpu_ack, cpu_wait       : CPU completion pulse and stall
//   ld_req/we/addr/wdata    : loader request bundle, same handshake
//   ld_ack                  : loader completion pulse
//   rdata                   : captured read data, held between reads
//   ram_enable/we/addr/wdata: RAM pins, ram_rdata: RAM read data
//   busy                    : an access is in flight (ACCESS or DONE)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int            CW       = cnt_w(ACCESS_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

  state_t              state, state_n;
  logic                last_grant;
  logic                gid;
  logic [CW-1:0]       cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                grant_valid;
  logic                grant_id;

  rr_arb2 u_rr (
    .req         ({ld_req, cpu_req & ~ld_mode}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_valid) state_n = ACCESS;
      ACCESS:  if (cnt == '0)   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_LD;   // CPU wins the first tie
      gid        <= GRANT_CPU;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          gid        <= grant_id;
          last_grant <= grant_id;
          cnt        <= CNT_INIT;
          if (grant_id == GRANT_LD) begin
            we_q    <= ld_we;
            addr_q  <= ld_addr;
            wdata_q <= ld_wdata;
          end else begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!we_q) rdata <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

  // Enable decodes straight from state so an async reset drops it at once.
  assign ram_enable = (state == ACCESS);
  assign ram_we     = ram_enable & we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign busy       = (state != IDLE);
  assign cpu_ack    = (state == DONE) && (gid == GRANT_CPU);
  assign ld_ack     = (state == DONE) && (gid == GRANT_LD);
  // Held low while reset is asserted so every output reads 0 in reset.
  assign cpu_wait   = reset & cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              ld_mode;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack, cpu_wait;
  logic              ld_req, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [DATA_W-1:0] rdata;
  logic              ram_enable, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .ld_mode(ld_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .rdata(rdata),
    .ram_enable(ram_enable), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Model RAM: asynchronous read, write on the clock edge while strobed.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) if (ram_enable && ram_we) mem[ram_addr] <= ram_wdata;

  // Structural invariants sampled every cycle.
  always @(negedge clock) begin
    checks++;
    if (ram_we && !ram_enable) begin
      errors++;
      $display("FAIL we_without_enable: ram_we=%b ram_enable=%b, required ram_we=0", ram_we, ram_enable);
    end
    checks++;
    if (cpu_ack && ld_ack) begin
      errors++;
      $display("FAIL two_acks: cpu_ack=%b ld_ack=%b, required at most one", cpu_ack, ld_ack);
    end
  end

  task automatic test_reset_and_cpu_read;
    logic [DATA_W*2+ADDR_W*2+6-1:0] outs;
    mem[5] = 32'hDEADBEEF;
    reset = 1'b0; ld_mode = 0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005; cpu_wdata = 32'h0;
    repeat (2) @(negedge clock);
    outs = {cpu_ack, cpu_wait, ld_ack, rdata, ram_enable, ram_we, ram_addr, ram_wdata, ram_addr, busy};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    reset = 1'b1;
    @(negedge clock);                       // 1st ACCESS cycle
    checks++;
    if (ram_enable !== 1 || busy !== 1 || ram_addr !== 9'h005) begin
      errors++;
      $display("FAIL first_grant: en=%b busy=%b addr=%h, required 1 1 005", ram_enable, busy, ram_addr);
    end
    @(negedge clock);                       // 2nd ACCESS cycle
    checks++;
    if (ram_enable !== 1 || cpu_ack !== 0 || cpu_wait !== 1) begin
      errors++;
      $display("FAIL access2: en=%b ack=%b wait=%b, required 1 0 1", ram_enable, cpu_ack, cpu_wait);
    end
    @(negedge clock);                       // DONE
    checks++;
    if (cpu_ack !== 1 || ld_ack !== 0 || ram_enable !== 0 || rdata !== 32'hDEADBEEF || cpu_wait !== 0) begin
      errors++;
      $display("FAIL cpu_read_ack: ack=%b ld_ack=%b en=%b rdata=%h wait=%b, required 1 0 0 deadbeef 0",
               cpu_ack, ld_ack, ram_enable, rdata, cpu_wait);
    end
    cpu_req = 0;
    @(negedge clock);                       // IDLE
    checks++;
    if (cpu_ack !== 0 || busy !== 0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ack_one_cycle: ack=%b busy=%b rdata=%h, required 0 0 deadbeef", cpu_ack, busy, rdata);
    end
  endtask

  task automatic test_load_then_read;
    ld_req = 1; ld_we = 1; ld_addr = 9'h1FF; ld_wdata = 32'h12345678;
    @(negedge clock);
    checks++;
    if (ram_we !== 1 || ram_addr !== 9'h1FF || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL ld_write_c1: we=%b addr=%h wdata=%h, required 1 1ff 12345678", ram_we, ram_addr, ram_wdata);
    end
    ld_addr = 9'h0AA; ld_wdata = 32'hFFFF0000;   // latched values must hold
    @(negedge clock);
    checks++;
    if (ram_we !== 1 || ram_addr !== 9'h1FF || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL ld_write_stable: we=%b addr=%h wdata=%h, required 1 1ff 12345678", ram_we, ram_addr, ram_wdata);
    end
    @(negedge clock);
    checks++;
    if (ld_ack !== 1 || cpu_ack !== 0 || ram_we !== 0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld_write_ack: ld_ack=%b cpu_ack=%b we=%b rdata=%h, required 1 0 0 deadbeef",
               ld_ack, cpu_ack, ram_we, rdata);
    end
    ld_req = 0; ld_we = 0;
    @(negedge clock);                       // IDLE
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      checks++;
      if (ram_enable !== 1 || ram_we !== 0 || ram_addr !== 9'h1FF) begin
        errors++;
        $display("FAIL cpu_read_access c%0d: en=%b we=%b addr=%h, required 1 0 1ff", c, ram_enable, ram_we, ram_addr);
      end
    end
    @(negedge clock);
    checks++;
    if (cpu_ack !== 1 || rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL cpu_readback: ack=%b rdata=%h, required 1 12345678", cpu_ack, rdata);
    end
    cpu_req = 0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic exp_ld;
    // Fresh reset so last_grant = LD and the CPU wins the first tie.
    reset = 0; @(negedge clock); reset = 1;
    mem[9'h010] = 32'hC0C0C0C0; mem[9'h020] = 32'h1D1D1D1D;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    ld_req  = 1; ld_we  = 0; ld_addr  = 9'h020;
    for (int k = 0; k < 4; k++) begin
      exp_ld = k[0];
      @(negedge clock);
      checks++;
      if (ram_addr !== (exp_ld ? 9'h020 : 9'h010)) begin
        errors++;
        $display("FAIL rr_grant k%0d: addr=%h, required %h", k, ram_addr, exp_ld ? 9'h020 : 9'h010);
      end
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (cpu_ack !== !exp_ld || ld_ack !== exp_ld ||
          rdata !== (exp_ld ? 32'h1D1D1D1D : 32'hC0C0C0C0)) begin
        errors++;
        $display("FAIL rr_ack k%0d: cpu_ack=%b ld_ack=%b rdata=%h, required %b %b %h", k,
                 cpu_ack, ld_ack, rdata, !exp_ld, exp_ld, exp_ld ? 32'h1D1D1D1D : 32'hC0C0C0C0);
      end
      @(negedge clock);
      checks++;
      if (cpu_ack !== 0 || ld_ack !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL rr_bubble k%0d: cpu_ack=%b ld_ack=%b busy=%b, required 0 0 0", k, cpu_ack, ld_ack, busy);
      end
    end
  endtask

  task automatic test_ld_mode;
    int ld_acks, cpu_acks, waits_low;
    ld_mode = 1;                            // both requests still held
    ld_acks = 0; cpu_acks = 0; waits_low = 0;
    repeat (12) begin
      @(negedge clock);
      ld_acks  += int'(ld_ack);
      cpu_acks += int'(cpu_ack);
      waits_low += int'(!cpu_wait);
    end
    checks++;
    if (ld_acks != 3 || cpu_acks != 0 || waits_low != 0) begin
      errors++;
      $display("FAIL ld_mode_lock: ld_acks=%0d cpu_acks=%0d wait_low=%0d, required 3 0 0", ld_acks, cpu_acks, waits_low);
    end
    ld_mode = 0;                            // now in IDLE bubble
    @(negedge clock);
    checks++;
    if (ram_addr !== 9'h010) begin
      errors++;
      $display("FAIL ld_mode_release: addr=%h, required 010 (CPU)", ram_addr);
    end
    cpu_req = 0; ld_req = 0;
    repeat (2) @(negedge clock);
    checks++;
    if (cpu_ack !== 1 || ld_ack !== 0) begin
      errors++;
      $display("FAIL ld_mode_cpu_ack: cpu_ack=%b ld_ack=%b, required 1 0", cpu_ack, ld_ack);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access;
    int acks;
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h033; cpu_wdata = 32'hAAAA5555;
    @(negedge clock);
    checks++;
    if (ram_enable !== 1 || ram_we !== 1) begin
      errors++;
      $display("FAIL wr_access: en=%b we=%b, required 1 1", ram_enable, ram_we);
    end
    @(posedge clock);
    #2;                                     // inside 2nd ACCESS cycle
    reset = 0;
    #1;
    checks++;
    if (ram_enable !== 0 || ram_we !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL async_reset: en=%b we=%b busy=%b, required 0 0 0", ram_enable, ram_we, busy);
    end
    cpu_req = 0; cpu_we = 0;
    @(negedge clock);
    reset = 1;
    acks = 0;
    repeat (4) begin
      @(negedge clock);
      acks += int'(cpu_ack) + int'(ld_ack);
    end
    checks++;
    if (acks != 0 || busy !== 0 || ram_enable !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: acks=%0d busy=%b en=%b, required 0 0 0", acks, busy, ram_enable);
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    test_reset_and_cpu_read();
    test_load_then_read();
    test_back_to_back();
    test_ld_mode();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
